// File: rtl/ps2_keycode_uart_tx.sv
// ps2_keycode_uart_tx: buffers PS/2 scan-code bytes in a FIFO and echoes
// each one over an 8N1 UART as two uppercase hex digits plus a space.
// Ports: clk, rstn (async, active-low); keycode/keycode_valid scan-byte
// input; clear_ovf clears the sticky overflow flag; tx serial line (idle
// high); busy while anything is queued, held or on the wire; fifo_count
// FIFO occupancy; overflow set when a byte is dropped on a full FIFO.
module ps2_keycode_uart_tx #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [7:0]                    keycode,
   input  logic                          keycode_valid,
   input  logic                          clear_ovf,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          full, empty;
   logic          push, pop, drop;

   state_t        state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          hold_vld_q;
   logic [7:0]    hold_q;
   logic [1:0]    char_q;
   logic          baud_done;
   logic [7:0]    head;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
   endfunction

   // idx 0: high nibble, 1: low nibble, 2: separating space
   function automatic logic [7:0] fmt_char(input logic [7:0] b,
                                           input logic [1:0] idx);
      logic [7:0] c;
      case (idx)
         2'd0:    c = hex_char(b[7:4]);
         2'd1:    c = hex_char(b[3:0]);
         default: c = 8'h20;
      endcase
      return c;
   endfunction

   assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign head      = mem_q[rd_ptr_q];
   assign baud_done = (baud_q == CW'(DIV - 1));

   // Fullness is judged on the registered count, so a pop in the same
   // cycle does not rescue a write into a full FIFO.
   always_comb begin
      push     = keycode_valid && !full;
      drop     = keycode_valid && full;
      pop      = !empty && !hold_vld_q && (state_q == S_IDLE);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (drop)
         ovf_d = 1'b1;
      else if (clear_ovf)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= keycode;
   end

   // The pop loads the hold register and the first character at once, so
   // the start bit begins the cycle after the pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
         char_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  hold_q     <= head;
                  hold_vld_q <= 1'b1;
                  char_q     <= 2'd1;
                  shift_q    <= fmt_char(head, 2'd0);
                  baud_q     <= '0;
                  tx_q       <= 1'b0;
                  state_q    <= S_START;
               end
            end
            S_START: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_DATA: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_STOP: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (hold_vld_q) begin
                     shift_q <= fmt_char(hold_q, char_q);
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                     // third character leaves, hold becomes free
                     if (char_q == 2'd2)
                        hold_vld_q <= 1'b0;
                     else
                        char_q <= char_q + 2'd1;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx         = tx_q;
   assign busy       = !empty || hold_vld_q || (state_q != S_IDLE);
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_keycode_uart_tx.sv
// tb_ps2_keycode_uart_tx: scoreboard bench; stimulus pushes expected
// characters with their start-bit times, a line monitor decodes tx.
module tb_ps2_keycode_uart_tx;

   localparam int DIV = 10;
   localparam int FD  = 8;
   localparam int FR  = 10 * DIV;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       keycode_valid = 1'b0;
   logic       clear_ovf = 1'b0;
   logic       tx, busy, overflow;
   logic [3:0] fifo_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] ch;
      int         t;
   } exp_t;

   exp_t exp_q[$];
   int   push_c[$];
   int   pop_c[$];
   int   start_c[$];
   bit   ev_drop[int];
   bit   ev_clr[int];
   bit   m_ovf = 1'b0;
   bit   chk_en = 1'b0;

   ps2_keycode_uart_tx #(
      .CLK_FREQ(1_000_000),
      .BAUD(100_000),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .keycode(keycode),
      .keycode_valid(keycode_valid),
      .clear_ovf(clear_ovf),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic logic [7:0] hexc(int n);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
   endfunction

   // Reference model: FIFO order, one line, 3 chars of FR cycles per byte,
   // pop no earlier than the cycle after the push or the line going idle.
   task automatic issue(bit v, logic [7:0] code, bit clr);
      int n, c, p, s;
      @(negedge clk);
      n = cyc;
      keycode_valid = v;
      keycode = code;
      clear_ovf = clr;
      if (clr) ev_clr[n] = 1'b1;
      if (v) begin
         c = 0;
         foreach (push_c[i]) begin
            if (push_c[i] < n) c++;
            if (pop_c[i] < n) c--;
         end
         if (c >= FD) begin
            ev_drop[n] = 1'b1;
         end else begin
            p = n + 1;
            if (start_c.size() > 0 && start_c[$] + 3 * FR > p)
               p = start_c[$] + 3 * FR;
            s = p + 1;
            push_c.push_back(n);
            pop_c.push_back(p);
            start_c.push_back(s);
            exp_q.push_back(exp_t'{hexc(int'(code[7:4])), s});
            exp_q.push_back(exp_t'{hexc(int'(code[3:0])), s + FR});
            exp_q.push_back(exp_t'{8'h20, s + 2 * FR});
         end
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 5000; i++) begin
         issue(1'b0, 8'h00, 1'b0);
         if (exp_q.size() == 0 && busy === 1'b0) break;
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_busy", busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      keycode_valid = 1'b0;
      clear_ovf = 1'b0;
      chk_en = 1'b0;
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      exp_q.delete();
      push_c.delete();
      pop_c.delete();
      start_c.delete();
      ev_drop.delete();
      ev_clr.delete();
      m_ovf = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      chk_en = 1'b1;
   endtask

   // Monitor: per-cycle state checks plus a mid-bit sampling UART decoder
   int         m_cnt;
   bit         m_busy;
   bit         rx_act = 1'b0;
   int         rx_t0;
   int         k;
   logic [7:0] rx_b;
   bit         stop_ok;
   exp_t       e;

   always @(negedge clk) begin
      if (!chk_en) begin
         rx_act = 1'b0;
      end else begin
         m_cnt = 0;
         m_busy = 1'b0;
         foreach (push_c[i]) begin
            if (push_c[i] < cyc) m_cnt++;
            if (pop_c[i] < cyc) m_cnt--;
            if (pop_c[i] <= cyc && cyc < start_c[i] + 3 * FR)
               m_busy = 1'b1;
         end
         if (m_cnt > 0) m_busy = 1'b1;
         if (ev_drop.exists(cyc - 1)) m_ovf = 1'b1;
         else if (ev_clr.exists(cyc - 1)) m_ovf = 1'b0;
         chk("fifo_count", fifo_count, m_cnt);
         chk("busy", busy, m_busy);
         chk("overflow", overflow, m_ovf);
         if (!rx_act) begin
            if (tx === 1'b0) begin
               rx_act = 1'b1;
               rx_t0 = cyc;
               rx_b = 8'h00;
               stop_ok = 1'b1;
            end
         end else begin
            k = cyc - rx_t0;
            if (k == DIV / 2)
               chk("start_bit", tx, 0);
            else if (k >= DIV + DIV / 2 && k < 9 * DIV
                     && (k % DIV) == DIV / 2)
               rx_b[(k - DIV - DIV / 2) / DIV] = tx;
            else if (k >= 9 * DIV)
               stop_ok = stop_ok && (tx === 1'b1);
            if (k == FR - 1) begin
               chk("stop_bit", stop_ok, 1);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame cyc=%0d got=%0h want=none",
                           cyc, rx_b);
               end else begin
                  e = exp_q.pop_front();
                  chk("char", rx_b, e.ch);
                  chk("char_start", rx_t0, e.t);
               end
               rx_act = 1'b0;
            end
         end
      end
   end

   int mx;
   int gap;

   initial begin
      do_reset();

      issue(1'b1, 8'h1C, 1'b0);
      issue(1'b0, 8'h00, 1'b0);
      chk("tx_n1_idle", tx, 1);
      issue(1'b0, 8'h00, 1'b0);
      chk("tx_n2_start", tx, 0);
      wait_done();

      issue(1'b1, 8'hF0, 1'b0);
      issue(1'b1, 8'h1C, 1'b0);
      wait_done();

      mx = 0;
      for (int i = 0; i < 10; i++) begin
         issue(1'b1, 8'(i), 1'b0);
         if (int'(fifo_count) > mx) mx = int'(fifo_count);
      end
      issue(1'b0, 8'h00, 1'b0);
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
      chk("fifo_peak", mx, 8);
      chk("ovf_set", overflow, 1);
      issue(1'b0, 8'h00, 1'b1);
      issue(1'b0, 8'h00, 1'b0);
      chk("ovf_cleared", overflow, 0);
      wait_done();

      for (int i = 0; i < 11; i++)
         issue(1'b1, 8'(8'h40 + i), (i == 10));
      issue(1'b0, 8'h00, 1'b0);
      chk("ovf_set_wins", overflow, 1);
      wait_done();
      issue(1'b0, 8'h00, 1'b1);

      issue(1'b1, 8'hA5, 1'b0);
      wait_done();

      for (int i = 0; i < 40; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400)
                                            : $urandom_range(0, 3);
         for (int j = 0; j < gap; j++)
            issue(1'b0, 8'h00, ($urandom_range(0, 29) == 0));
         issue(1'b1, 8'($urandom), ($urandom_range(0, 29) == 0));
      end
      wait_done();

      issue(1'b1, 8'h12, 1'b0);
      issue(1'b1, 8'h34, 1'b0);
      issue(1'b1, 8'h56, 1'b0);
      repeat (150) issue(1'b0, 8'h00, 1'b0);
      do_reset();
      repeat (500) issue(1'b0, 8'h00, 1'b0);
      chk("post_reset_tx", tx, 1);
      chk("post_reset_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
